// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback sources,
// with one registered output stage. Define REGFILE_WB_BYPASS_EN to add read forwarding.
module regfile_wb_arbiter #(
  parameter  int NREQ = 2,
  parameter  int AW   = 5,
  parameter  int DW   = 32,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               wb_stall,
  output logic               we3,
  output logic [AW-1:0]      wa3,
  output logic [DW-1:0]      wd3,
  output logic [IW-1:0]      grant_id
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]      ra1,
  input  logic [AW-1:0]      ra2,
  input  logic [DW-1:0]      rf_rd1,
  input  logic [DW-1:0]      rf_rd2,
  output logic [DW-1:0]      rd1,
  output logic [DW-1:0]      rd2
`endif
);

  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q,  out_addr_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [IW-1:0] out_id_q,    out_id_d;
  logic [IW-1:0] ptr_q,       ptr_d;

  logic          advance;
  logic          grant_en;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  assign advance  = ~out_valid_q | ~wb_stall;
  // A stalled port never grants, even when the output stage is empty.
  assign grant_en = advance & ~wb_stall;

  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(ptr_q) + k) % 32'(NREQ);
      cand_idx = IW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_addr = req_addr[win_idx*AW +: AW];
  assign win_data = req_data[win_idx*DW +: DW];

  always_comb begin
    req_ready = '0;
    if (grant_en && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (grant_en) begin
      if (win_found) begin
        ptr_d       = win_idx;
        out_addr_d  = win_addr;
        out_data_d  = win_data;
        out_id_d    = win_idx;
        // r0 writes complete the handshake but never reach the port.
        out_valid_d = (win_addr != '0);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= IW'(NREQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign we3      = out_valid_q & ~wb_stall;
  assign wa3      = out_addr_q;
  assign wd3      = out_data_q;
  assign grant_id = out_id_q;

`ifdef REGFILE_WB_BYPASS_EN
  assign rd1 = (out_valid_q && (ra1 != '0) && (ra1 == out_addr_q)) ? out_data_q : rf_rd1;
  assign rd2 = (out_valid_q && (ra2 != '0) && (ra2 == out_addr_q)) ? out_data_q : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a cycle-level reference model.
// Define REGFILE_WB_BYPASS_EN to also check read forwarding.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IW   = $clog2(NREQ);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               wb_stall;
  logic               we3;
  logic [AW-1:0]      wa3;
  logic [DW-1:0]      wd3;
  logic [IW-1:0]      grant_id;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0]      ra1, ra2;
  logic [DW-1:0]      rf_rd1, rf_rd2, rd1, rd2;
`endif

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wb_stall  (wb_stall),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .grant_id  (grant_id)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .ra1       (ra1),
    .ra2       (ra2),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .rd1       (rd1),
    .rd2       (rd2)
`endif
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port.
  logic [DW-1:0] tb_rf [32];
  always @(posedge clk) if (we3) tb_rf[wa3] <= wd3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int            m_ptr;
  bit            m_ov;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_id;
  logic [DW-1:0] m_rf [32];
  int            last_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr  = NREQ - 1;
    m_ov   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_id   = 0;
  endfunction

  function automatic int winner();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Called at posedge+1: checks outputs at the negedge, then advances the model over the edge.
  task automatic step();
    int w;
    logic [31:0] er;
    @(negedge clk);
    w  = wb_stall ? -1 : winner();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", 32'(req_ready), er);
    check("we3", 32'(we3), 32'(m_ov && !wb_stall));
    check("wa3", 32'(wa3), 32'(m_addr));
    check("wd3", wd3, m_data);
    check("grant_id", 32'(grant_id), 32'(m_id));
`ifdef REGFILE_WB_BYPASS_EN
    check("rd1", rd1, (m_ov && ra1 != 0 && ra1 == m_addr) ? m_data : rf_rd1);
    check("rd2", rd2, (m_ov && ra2 != 0 && ra2 == m_addr) ? m_data : rf_rd2);
`endif
    @(posedge clk);
    if (m_ov && !wb_stall) m_rf[m_addr] = m_data;
    if (!wb_stall) begin
      if (w >= 0) begin
        m_ptr  = w;
        m_id   = w;
        m_addr = req_addr[w*AW +: AW];
        m_data = req_data[w*DW +: DW];
        m_ov   = (m_addr != 0);
      end else begin
        m_ov = 1'b0;
      end
    end
    last_w = w;
    #1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      tb_rf[r] = '0;
      m_rf[r]  = '0;
    end
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    wb_stall  = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    ra1 = '0; ra2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin from reset: grants alternate 0,1 with no bubble.
    set_req(0, 1'b1, 5'd3, 32'h0000_0333);
    set_req(1, 1'b1, 5'd4, 32'h0000_0444);
    for (int c = 0; c < 4; c++) begin
      step();
      check("rr_grant", 32'(grant_id), 32'(c % 2));
      check("rr_wa3", 32'(wa3), (c % 2 == 0) ? 32'd3 : 32'd4);
      check("rr_we3", 32'(we3), 32'd1);
    end
    req_valid = '0;
    step();

    // Single write to r5.
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    req_valid = '0;
    check("sw_we3", 32'(we3), 32'd1);
    check("sw_wd3", wd3, 32'hDEAD_BEEF);
    step();
    step();
    check("sw_rf5", tb_rf[5], 32'hDEAD_BEEF);

    // Stall with a pending write to r9.
    set_req(0, 1'b1, 5'd9, 32'h0909_0909);
    step();
    req_valid = '0;
    wb_stall  = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("stall_wa3", 32'(wa3), 32'd9);
    check("stall_we3", 32'(we3), 32'd0);
    wb_stall = 1'b0;
    step();
    step();
    check("stall_after_we3", 32'(we3), 32'd0);

    // r0 write is accepted then discarded.
    set_req(1, 1'b1, 5'd0, 32'h0000_1234);
    step();
    req_valid = '0;
    check("r0_we3", 32'(we3), 32'd0);
    step();
    check("r0_rf0", tb_rf[0], 32'd0);

    // Reset asserted while a write to r7 sits in the output stage.
    set_req(0, 1'b1, 5'd7, 32'h7777_7777);
    step();
    req_valid = '0;
    check("mid_wa3_pre", 32'(wa3), 32'd7);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_we3", 32'(we3), 32'd0);
    check("mid_wa3", 32'(wa3), 32'd0);
    check("mid_wd3", wd3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = '1;
    step();
    check("mid_first_grant", 32'(grant_id), 32'd0);

`ifdef REGFILE_WB_BYPASS_EN
    // Forwarding from the output stage.
    req_valid = '0;
    set_req(2, 1'b1, 5'd12, 32'hA5A5_A5A5);
    step();
    req_valid = '0;
    ra1 = 5'd12; rf_rd1 = '0; ra2 = 5'd0; rf_rd2 = 32'h1357_9BDF;
    #1;
    check("byp_rd1", rd1, 32'hA5A5_A5A5);
    check("byp_rd2", rd2, 32'h1357_9BDF);
    step();
`endif

    // Randomized traffic; requesters hold their request until accepted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && last_w != i)) begin
          set_req(i, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom);
        end
      end
      wb_stall = m_ov && ($urandom_range(0, 3) == 0);
`ifdef REGFILE_WB_BYPASS_EN
      ra1    = $urandom_range(0, 1) ? m_addr : 5'($urandom_range(0, 31));
      ra2    = 5'($urandom_range(0, 31));
      rf_rd1 = $urandom;
      rf_rd2 = $urandom;
`endif
      step();
    end
    req_valid = '0;
    wb_stall  = 1'b0;
    step();
    step();
    for (int r = 0; r < 32; r++) check("rf_final", tb_rf[r], m_rf[r]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
